// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time,
// holds the returned word for decode and steers the next PC from PCSel.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] inst_pc4,
    input  logic            inst_ready,
    input  logic [1:0]      PCSel,
    input  logic [XLEN-1:0] br_target,
    input  logic [XLEN-1:0] jalr_target,
    output logic            misalign_err,
    output logic [31:0]     inst_count
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_ERR
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_inst;
    logic [XLEN-1:0] r_inst_pc;
    logic            r_inst_valid;
    logic            r_misalign;
    logic [31:0]     r_count;

    logic            w_accept;
    logic [XLEN-1:0] w_next_pc;
    logic            w_misaligned;

    assign w_accept = (r_state == S_HOLD) && r_inst_valid && inst_ready;

    always_comb begin
        w_next_pc = r_pc + XLEN'(4);
        case (PCSel)
            2'b01:   w_next_pc = br_target;
            2'b10:   w_next_pc = {jalr_target[XLEN-1:1], 1'b0};
            default: w_next_pc = r_pc + XLEN'(4);
        endcase
    end

    assign w_misaligned = |w_next_pc[1:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_REQ:   w_state_nxt = S_WAIT;
            S_WAIT:  if (imem_rvalid) w_state_nxt = S_HOLD;
            S_HOLD:  if (w_accept) w_state_nxt = w_misaligned ? S_ERR : S_REQ;
            S_ERR:   w_state_nxt = S_ERR;
            default: w_state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_inst       <= 32'h0000_0013;
            r_inst_pc    <= RESET_PC;
            r_inst_valid <= 1'b0;
            r_misalign   <= 1'b0;
            r_count      <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_inst       <= imem_rdata;
                        r_inst_pc    <= r_pc;
                        r_inst_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_accept) begin
                        r_count      <= r_count + 32'd1;
                        r_inst_valid <= 1'b0;
                        if (w_misaligned) r_misalign <= 1'b1;
                        else              r_pc       <= w_next_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Gated by rst_n so no request strobe is visible while reset is held.
    assign imem_req     = rst_n && (r_state == S_REQ);
    assign imem_addr    = r_pc;
    assign inst_valid   = r_inst_valid;
    assign inst         = r_inst;
    assign inst_pc      = r_inst_pc;
    assign inst_pc4     = r_inst_pc + XLEN'(4);
    assign misalign_err = r_misalign;
    assign inst_count   = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit: a memory/decode model pushes
// expected requests, instructions and errors; a monitor pops and compares.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;
    logic        inst_ready;
    logic [1:0]  PCSel;
    logic [31:0] br_target;
    logic [31:0] jalr_target;
    logic        misalign_err;
    logic [31:0] inst_count;

    fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_pc4(inst_pc4),
        .inst_ready(inst_ready), .PCSel(PCSel),
        .br_target(br_target), .jalr_target(jalr_target),
        .misalign_err(misalign_err), .inst_count(inst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] cnt;
        bit          fast;
    } req_t;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
        logic [31:0] pc4;
    } inst_t;

    req_t        req_q[$];
    inst_t       inst_q[$];
    logic [31:0] err_q[$];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick_target();
        int unsigned r;
        r = $urandom_range(0, 19);
        if (r == 0) return 32'hFFFF_FFFC;
        if (r == 1) return 32'hFFFF_FFF8;
        if (r == 2) return ($urandom & 32'hFFFF_FFFC) | 32'h2;
        return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    endfunction

    // Reference model: architectural PC, retire count and error flag.
    logic [31:0] model_pc;
    logic [31:0] model_count;
    logic [31:0] nxt;
    logic [31:0] pend_pc;
    bit          model_err, pending, held, valid_now, fast;
    int unsigned cd, lat, rst_left, err_wait;
    req_t        re;
    inst_t       ie;

    initial begin
        rst_n = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
        PCSel = 2'b00; br_target = '0; jalr_target = '0;
        model_pc = RESET_PC; model_count = '0; model_err = 0;
        pending = 0; held = 0; fast = 1; cd = 0; lat = 1; rst_left = 4; err_wait = 0;
        pend_pc = RESET_PC;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(posedge clk); #1;
            imem_rvalid = 1'b0;
            lat = fast ? 1 : $urandom_range(1, 6);
            if (model_err && rst_n) begin
                if (err_wait == 0) rst_left = 1;
                else err_wait--;
            end
            if (!fast && rst_n && pending && $urandom_range(0, 29) == 0) rst_left = 1;

            if (rst_left > 0) begin
                rst_left--;
                rst_n = 1'b0;
                req_q.delete(); inst_q.delete(); err_q.delete();
                model_pc = RESET_PC; model_count = '0; model_err = 0;
                pending = 0; held = 0;
                re.addr = RESET_PC; re.cnt = '0; re.fast = 0;
                req_q.push_back(re);
                inst_ready = 1'($urandom_range(0, 1));
            end else if (!rst_n) begin
                // Release reset: the DUT requests RESET_PC now, so a stray
                // rvalid driven alongside must be ignored.
                rst_n = 1'b1;
                imem_rvalid = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
                pending = 1; cd = lat; pend_pc = model_pc;
            end else begin
                valid_now = held;
                inst_ready  = fast ? 1'b1 : ($urandom_range(0, 2) != 0);
                PCSel       = fast ? 2'b00 : 2'($urandom_range(0, 3));
                br_target   = pick_target();
                jalr_target = pick_target() | 32'($urandom_range(0, 1));

                if (valid_now && inst_ready) begin
                    model_count = model_count + 32'd1;
                    case (PCSel)
                        2'b01:   nxt = br_target;
                        2'b10:   nxt = jalr_target & ~32'd1;
                        default: nxt = model_pc + 32'd4;
                    endcase
                    held = 0;
                    if (nxt % 4 != 0) begin
                        model_err = 1; err_wait = 5;
                        err_q.push_back(model_count);
                    end else begin
                        model_pc = nxt;
                        re.addr = nxt; re.cnt = model_count; re.fast = fast;
                        req_q.push_back(re);
                    end
                    if (fast && model_count == 4) fast = 0;
                end

                if (pending) begin
                    if (cd <= 1) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = $urandom;
                        ie.word = imem_rdata; ie.pc = pend_pc; ie.pc4 = pend_pc + 32'd4;
                        inst_q.push_back(ie);
                        pending = 0; held = 1;
                    end else begin
                        cd--;
                    end
                end
                if (imem_req) begin
                    pending = 1; cd = lat; pend_pc = model_pc;
                end
            end
        end
        @(posedge clk); #1;
        imem_rvalid = 1'b0; inst_ready = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("req_queue_drained", 32'(req_q.size()), 32'd0);
        chk("inst_queue_drained", 32'(inst_q.size()), 32'd0);
        chk("err_queue_drained", 32'(err_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Monitor: samples on the falling edge, compares against the queues.
    bit          prev_rst_low = 0, prev_req = 0, prev_valid = 0, prev_err = 0, have_last = 0;
    int unsigned mcyc = 0, last_req = 0;
    inst_t       cur;
    req_t        got;
    logic [31:0] err_cnt_exp = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                if (prev_rst_low) begin
                    chk("rst_imem_req", 32'(imem_req), 32'd0);
                    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
                    chk("rst_inst", inst, 32'h0000_0013);
                    chk("rst_inst_pc", inst_pc, RESET_PC);
                    chk("rst_misalign", 32'(misalign_err), 32'd0);
                    chk("rst_count", inst_count, 32'd0);
                end
                prev_rst_low = 1; prev_req = 0; prev_valid = 0; prev_err = 0; have_last = 0;
                continue;
            end
            prev_rst_low = 0;
            mcyc++;

            if (imem_req) begin
                if (prev_req) chk("req_single_cycle", 32'(prev_req), 32'd0);
                if (req_q.size() == 0) begin
                    chk("unexpected_req", imem_addr, 32'hFFFF_FFFF);
                end else begin
                    got = req_q.pop_front();
                    chk("req_addr", imem_addr, got.addr);
                    chk("req_count", inst_count, got.cnt);
                    if (got.fast && have_last) chk("req_spacing", 32'(mcyc - last_req), 32'd3);
                end
                last_req = mcyc; have_last = 1;
            end
            prev_req = imem_req;

            if (inst_valid && !prev_valid) begin
                if (inst_q.size() == 0) begin
                    chk("unexpected_inst", inst_pc, 32'hFFFF_FFFF);
                    cur.word = inst; cur.pc = inst_pc; cur.pc4 = inst_pc4;
                end else begin
                    cur = inst_q.pop_front();
                    chk("inst_word", inst, cur.word);
                    chk("inst_pc", inst_pc, cur.pc);
                    chk("inst_pc4", inst_pc4, cur.pc4);
                end
            end else if (inst_valid) begin
                chk("hold_stable", 32'({inst == cur.word, inst_pc == cur.pc, inst_pc4 == cur.pc4}), 32'd7);
            end
            prev_valid = inst_valid;

            if (misalign_err && !prev_err) begin
                if (err_q.size() == 0) begin
                    chk("unexpected_err", 32'(misalign_err), 32'd0);
                    err_cnt_exp = inst_count;
                end else begin
                    err_cnt_exp = err_q.pop_front();
                end
            end
            if (misalign_err) begin
                chk("err_no_req", 32'(imem_req), 32'd0);
                chk("err_inst_valid", 32'(inst_valid), 32'd0);
                chk("err_count", inst_count, err_cnt_exp);
            end
            prev_err = misalign_err;
        end
    end

endmodule
